// File: rtl/load_store_unit.sv
// Load/store unit: turns one load/store request at a time into word-wide memory cycles.
// Optional LSU_BOUNDS_CHECK_EN rejects word indices at or beyond DEPTH.
module load_store_unit #(
    parameter int unsigned DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        FIN
    } state_t;

    if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("load_store_unit: DEPTH must be a power of two");
    end

    state_t      state;
    state_t      state_next;
    logic        mem_read_next;
    logic        mem_write_next;
    logic        illegal;
    logic        oob;
    logic        transfer;

    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        err_q;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = (req_addr[31:2] >= 30'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    assign illegal = (req_read == req_write)
                   || (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                   || oob;

    assign req_ready = (state == IDLE);
    assign transfer  = req_valid && req_ready;
    assign done      = (state == FIN);
    assign err       = (state == FIN) && err_q;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (sz)
            2'd0:    extend = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] lo, input logic [1:0] sz);
        logic [31:0] mask;
        logic [31:0] data;
        mask  = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << {lo, 3'b000};
        data  = d << {lo, 3'b000};
        merge = (w & ~mask) | (data & mask);
    endfunction

    // Illegal requests pass through WR with the write strobe suppressed, so err
    // completes two cycles after transfer like a word store.
    always_comb begin
        state_next     = state;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal)                state_next = WR;
                    else if (req_read)          state_next = RD;
                    else if (req_size == 2'd2)  state_next = WR;
                    else                        state_next = RMW_RD;
                end
            end
            RD:      state_next = CAP;
            CAP:     state_next = FIN;
            WR:      state_next = FIN;
            RMW_RD:  state_next = RMW_MRG;
            RMW_MRG: state_next = RMW_WR;
            RMW_WR:  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        mem_read_next  = (state_next == RD) || (state_next == RMW_RD);
        mem_write_next = (state == IDLE && state_next == WR && !illegal) || (state_next == RMW_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state     <= state_next;
            mem_read  <= mem_read_next;
            mem_write <= mem_write_next;
            if (transfer) begin
                addr_lo_q <= req_addr[1:0];
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                wdata_q   <= req_wdata;
                err_q     <= illegal;
                if (!illegal) begin
                    mem_address <= {2'b00, req_addr[31:2]};
                    if (req_write) mem_wdata <= req_wdata;
                end
            end
            if (state == CAP) begin
                rdata <= extend(mem_rdata, addr_lo_q, size_q, uns_q);
            end
            if (state == RMW_MRG) begin
                mem_wdata <= merge(mem_rdata, wdata_q, addr_lo_q, size_q);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a simple 128-word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];
    logic        pre_en;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;

    load_store_unit #(.DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_address[6:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_address[6:0]];
    end

    task automatic preload(input logic [6:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge with the unit idle; returns at the negedge after done.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int dcyc, output logic e, output logic [31:0] rdat,
                           output int nrd, output int nwr, output logic [31:0] radr,
                           output logic [31:0] wadr, output logic [31:0] wdat,
                           output int wcyc, output int rdy_bad);
        dcyc = -1; e = 1'b0; rdat = '0; nrd = 0; nwr = 0; radr = '0; wadr = '0;
        wdat = '0; wcyc = -1; rdy_bad = 0;
        if (!req_ready) rdy_bad++;
        req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_read = ~rd; req_write = ~wr; req_size = ~sz;
        req_unsigned = ~uns; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_read) begin nrd++; radr = mem_address; end
            if (mem_write) begin nwr++; wadr = mem_address; wdat = mem_wdata; wcyc = k; end
            if (req_ready) rdy_bad++;
            if (done) begin dcyc = k; e = err; rdat = rdata; break; end
        end
        @(negedge clk);
        if (!req_ready) rdy_bad++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; pre_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if ({done, err, mem_read, mem_write} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {done, err, mem_read, mem_write}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if ({mem_address, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus got %h exp 0", {mem_address, mem_wdata}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready %b done %b exp 1 0", req_ready, done); end
    endtask

    task automatic test_word_store_load();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (wc !== 1 || nw !== 1) begin errors++; $display("FAIL sw_write_cycle got cyc %0d cnt %0d exp 1 1", wc, nw); end
        checks++; if (wa !== 32'd4 || wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_bus got %h/%h exp 4/deadbeef", wa, wd); end
        checks++; if (dc !== 2 || e !== 1'b0 || nr !== 0) begin errors++; $display("FAIL sw_done got %0d err %b rd %0d exp 2 0 0", dc, e, nr); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL sw_ready got %0d bad exp 0", rb); end
        run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (dc !== 3 || e !== 1'b0) begin errors++; $display("FAIL lw_done got %0d err %b exp 3 0", dc, e); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
        checks++; if (nr !== 1 || ra !== 32'd4 || nw !== 0) begin errors++; $display("FAIL lw_bus got rd %0d addr %h wr %0d exp 1 4 0", nr, ra, nw); end
    endtask

    task automatic test_sub_store();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        preload(7'd4, 32'h1122_3344);
        run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56AA, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (wd !== 32'h1122_AA44 || wa !== 32'd4) begin errors++; $display("FAIL sb_merge got %h@%h exp 1122aa44@4", wd, wa); end
        checks++; if (dc !== 4 || wc !== 3 || e !== 1'b0) begin errors++; $display("FAIL sb_timing got done %0d wr %0d err %b exp 4 3 0", dc, wc, e); end
        checks++; if (nr !== 1 || nw !== 1 || rb !== 0) begin errors++; $display("FAIL sb_strobes got rd %0d wr %0d rdy %0d exp 1 1 0", nr, nw, rb); end
        checks++; if (mem[4] !== 32'h1122_AA44) begin errors++; $display("FAIL sb_mem got %h exp 1122aa44", mem[4]); end
        run_req(1'b0, 1'b1, 2'd1, 1'b1, 32'h12, 32'hFFFF_BEEF, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (wd !== 32'hBEEF_AA44 || dc !== 4) begin errors++; $display("FAIL sh_merge got %h done %0d exp beefaa44 4", wd, dc); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold_store got %h exp deadbeef", rdata); end
    endtask

    task automatic test_load_ext();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        logic [33:0] vec [6];
        logic [31:0] addr [6];
        logic [31:0] exp [6];
        preload(7'd4, 32'h80FF_7F01);
        // {size, unsigned} encoded in vec; address and expected value alongside
        vec[0] = {2'd0, 32'd0}; addr[0] = 32'h13; exp[0] = 32'hFFFF_FF80;
        vec[1] = {2'd0, 32'd1}; addr[1] = 32'h13; exp[1] = 32'h0000_0080;
        vec[2] = {2'd1, 32'd0}; addr[2] = 32'h12; exp[2] = 32'hFFFF_80FF;
        vec[3] = {2'd0, 32'd0}; addr[3] = 32'h12; exp[3] = 32'hFFFF_FFFF;
        vec[4] = {2'd0, 32'd1}; addr[4] = 32'h11; exp[4] = 32'h0000_007F;
        vec[5] = {2'd1, 32'd1}; addr[5] = 32'h10; exp[5] = 32'h0000_7F01;
        for (int i = 0; i < 6; i++) begin
            run_req(1'b1, 1'b0, vec[i][33:32], vec[i][0], addr[i], 32'h0, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
            checks++;
            if (rd !== exp[i] || dc !== 3 || e !== 1'b0) begin
                errors++; $display("FAIL load_ext_%0d got %h done %0d err %b exp %h 3 0", i, rd, dc, e, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        logic [36:0] vec [5];
        vec[0] = {1'b1, 1'b0, 2'd1, 1'b0, 32'h11};
        vec[1] = {1'b0, 1'b1, 2'd2, 1'b0, 32'h12};
        vec[2] = {1'b1, 1'b0, 2'd3, 1'b0, 32'h10};
        vec[3] = {1'b1, 1'b1, 2'd2, 1'b0, 32'h10};
        vec[4] = {1'b0, 1'b0, 2'd0, 1'b0, 32'h10};
        for (int i = 0; i < 5; i++) begin
            run_req(vec[i][36], vec[i][35], vec[i][34:33], vec[i][32], vec[i][31:0], 32'h5555_5555,
                    dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
            checks++;
            if (dc !== 2 || e !== 1'b1 || nr !== 0 || nw !== 0 || rb !== 0) begin
                errors++; $display("FAIL illegal_%0d got done %0d err %b rd %0d wr %0d rdy %0d exp 2 1 0 0 0", i, dc, e, nr, nw, rb);
            end
        end
        checks++; if (rdata !== 32'h0000_7F01) begin errors++; $display("FAIL rdata_hold_err got %h exp 00007f01", rdata); end
        checks++; if (mem[4] !== 32'h80FF_7F01) begin errors++; $display("FAIL illegal_mem got %h exp 80ff7f01", mem[4]); end
    endtask

    task automatic test_oob();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        preload(7'd0, 32'hCAFE_F00D);
        run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
`ifdef LSU_BOUNDS_CHECK_EN
        checks++; if (dc !== 2 || e !== 1'b1 || nr !== 0) begin errors++; $display("FAIL oob_err got done %0d err %b rd %0d exp 2 1 0", dc, e, nr); end
`else
        checks++; if (nr !== 1 || ra !== 32'h80) begin errors++; $display("FAIL oob_addr got rd %0d addr %h exp 1 80", nr, ra); end
        checks++; if (dc !== 3 || e !== 1'b0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL oob_wrap got done %0d err %b data %h exp 3 0 cafef00d", dc, e, rd); end
`endif
    endtask

    task automatic test_back_to_back();
        int dc, nr, nw, wc, rb; logic e; logic [31:0] rd, ra, wa, wd;
        run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1111_2222, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (dc !== 2 || rb !== 0 || wa !== 32'h10) begin errors++; $display("FAIL b2b_store got done %0d rdy %0d addr %h exp 2 0 10", dc, rb, wa); end
        run_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, dc, e, rd, nr, nw, ra, wa, wd, wc, rb);
        checks++; if (dc !== 3 || rb !== 0 || rd !== 32'h0000_1111) begin errors++; $display("FAIL b2b_load got done %0d rdy %0d data %h exp 3 0 00001111", dc, rb, rd); end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        wr_seen = 0;
        preload(7'd8, 32'h5566_7788);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'd1;
        req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmw_read got %b exp 1", mem_read); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_write !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset got ready %b wr %b done %b exp 1 0 0", req_ready, mem_write, done); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1'b1;
            if (mem_write) wr_seen++;
        end
        checks++; if (wr_seen !== 0 || mem[8] !== 32'h5566_7788) begin errors++; $display("FAIL mid_reset_mem got writes %0d word %h exp 0 55667788", wr_seen, mem[8]); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got %b exp 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_sub_store();
        test_load_ext();
        test_illegal();
        test_oob();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
